// File: rtl/ps_linebuffer_pkg.sv
// ps_linebuffer_pkg: shared state encoding, edge-mode
// constants and kernel helpers for the windowed linebuffer.
package ps_linebuffer_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PRIME,
    ST_READ
  } lb_state_t;

  localparam int EDGE_ZERO      = 0;
  localparam int EDGE_REPLICATE = 1;

  function automatic int half_width(input int kernel);
    return (kernel - 1) / 2;
  endfunction

endpackage

// File: rtl/ps_lb_ram.sv
// ps_lb_ram: simple dual-port line RAM, one write port and
// one synchronous read port with a single cycle of latency.
module ps_lb_ram #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_LENGTH = 640,
  parameter int ADDR_WIDTH  = $clog2(LINE_LENGTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [LINE_LENGTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ps_linebuffer_win.sv
// ps_linebuffer_win: single-line buffer emitting a KERNEL-wide
// window per read. Optional o_count via PS_LINEBUFFER_WIN_COUNT_EN.
module ps_linebuffer_win
  import ps_linebuffer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_LENGTH = 640,
  parameter int KERNEL      = 3,
  parameter int EDGE_MODE   = EDGE_ZERO
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  output logic                         o_wr_drop,
  input  logic                         i_rd,
  output logic                         o_rdy,
  output logic [KERNEL*DATA_WIDTH-1:0] o_rdata,
  output logic                         o_rvalid,
`ifdef PS_LINEBUFFER_WIN_COUNT_EN
  output logic [$clog2(LINE_LENGTH+1)-1:0] o_count,
`endif
  output logic                         o_line_done
);

  localparam int H  = half_width(KERNEL);
  localparam int AW = $clog2(LINE_LENGTH);
  localparam int XW = $clog2(LINE_LENGTH + KERNEL);
  localparam int PW = $clog2(H + 2) + 1;
  localparam bit REPL = (EDGE_MODE == EDGE_REPLICATE);

  localparam logic [AW-1:0] W_LAST  = AW'(LINE_LENGTH - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(LINE_LENGTH - 1);
  localparam logic [XW-1:0] X_END   = XW'(LINE_LENGTH);
  localparam logic [XW-1:0] X_AHEAD = XW'(H + 1);
  localparam logic [PW-1:0] P_FIRST = PW'(1);
  localparam logic [PW-1:0] P_LAST  = PW'(H + 1);

  lb_state_t state;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_nxt;
  logic [XW-1:0] rd_x;
  logic [PW-1:0] pcnt;

  logic [KERNEL-1:0][DATA_WIDTH-1:0] win;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] tap_in;

  logic accept;
  logic wr_en;
  logic x_last;
  logic ahead_in;

  assign accept   = i_rd & o_rdy;
  assign wr_en    = i_wr & (state == ST_FILL);
  assign x_last   = (rd_x == X_LAST);
  assign ahead_in = (rd_x + X_AHEAD) < X_END;

  // win[0] is the newest tap, so it already holds the
  // right-edge pixel once the line has run out.
  assign tap_in = ahead_in ? q : (REPL ? win[0] : '0);

  // RAM address runs one step ahead so q always holds p[rptr].
  always_comb begin
    rptr_nxt = rptr;
    if (state == ST_PRIME) begin
      if (pcnt != '0) rptr_nxt = rptr + 1'b1;
    end else if (accept && x_last) begin
      rptr_nxt = '0;
    end else if (accept && rptr != W_LAST) begin
      rptr_nxt = rptr + 1'b1;
    end
  end

  ps_lb_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_LENGTH(LINE_LENGTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk  (i_clk),
    .we   (wr_en),
    .waddr(wptr),
    .wdata(i_wdata),
    .raddr(rptr_nxt),
    .rdata(q)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_FILL;
      wptr        <= '0;
      rptr        <= '0;
      rd_x        <= '0;
      pcnt        <= '0;
      win         <= '0;
      o_rdy       <= 1'b0;
      o_rdata     <= '0;
      o_rvalid    <= 1'b0;
      o_line_done <= 1'b0;
      o_wr_drop   <= 1'b0;
    end else begin
      rptr        <= rptr_nxt;
      o_wr_drop   <= i_wr & (state != ST_FILL);
      o_rvalid    <= accept;
      o_line_done <= accept & x_last;
      unique case (state)
        ST_FILL: begin
          if (wr_en) begin
            if (wptr == W_LAST) begin
              wptr  <= '0;
              pcnt  <= '0;
              state <= ST_PRIME;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        ST_PRIME: begin
          pcnt <= pcnt + 1'b1;
          // p[0] seeds every left tap: zero or replicated edge.
          if (pcnt == P_FIRST) begin
            for (int i = 0; i < KERNEL; i++)
              win[i] <= (i == 0 || REPL) ? q : '0;
          end else if (pcnt != '0) begin
            win <= {win[KERNEL-2:0], q};
          end
          if (pcnt == P_LAST) begin
            state <= ST_READ;
            o_rdy <= 1'b1;
            rd_x  <= '0;
          end
        end
        ST_READ: begin
          if (accept) begin
            o_rdata <= win;
            win     <= {win[KERNEL-2:0], tap_in};
            rd_x    <= rd_x + 1'b1;
            if (x_last) begin
              state <= ST_FILL;
              o_rdy <= 1'b0;
              rd_x  <= '0;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

`ifdef PS_LINEBUFFER_WIN_COUNT_EN
  // Counts up while filling, down while reading out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (wr_en) begin
      o_count <= o_count + 1'b1;
    end else if (accept) begin
      o_count <= o_count - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ps_linebuffer_win.sv
// tb_ps_linebuffer_win: scoreboard bench driving three linebuffer
// configurations (K3 zero, K3 replicate, K5 replicate).
module tb_ps_linebuffer_win;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int LL = 8;

  localparam logic [39:0] T0 [8] = '{
    40'h001011, 40'h101112, 40'h111213, 40'h121314,
    40'h131415, 40'h141516, 40'h151617, 40'h161700};
  localparam logic [39:0] T1 [8] = '{
    40'h101011, 40'h101112, 40'h111213, 40'h121314,
    40'h131415, 40'h141516, 40'h151617, 40'h161717};
  localparam logic [39:0] T2 [8] = '{
    40'h1010101112, 40'h1010111213, 40'h1011121314,
    40'h1112131415, 40'h1213141516, 40'h1314151617,
    40'h1415161717, 40'h1516171717};

  typedef struct {
    int          d;
    int          x;
    logic [39:0] data;
    logic        last;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic wr [N];
  logic rd [N];
  logic [DW-1:0] wdata [N];
  logic wr_drop [N];
  logic rdy [N];
  logic rvalid [N];
  logic line_done [N];
  logic [39:0] rdata [N];
`ifdef PS_LINEBUFFER_WIN_COUNT_EN
  logic [3:0] count [N];
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  exp_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int K = (g == 2) ? 5 : 3;
    logic [K*DW-1:0] rdw;
    ps_linebuffer_win #(
      .DATA_WIDTH (DW),
      .LINE_LENGTH(LL),
      .KERNEL     (K),
      .EDGE_MODE  ((g == 0) ? 0 : 1)
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wr       (wr[g]),
      .i_wdata    (wdata[g]),
      .o_wr_drop  (wr_drop[g]),
      .i_rd       (rd[g]),
      .o_rdy      (rdy[g]),
      .o_rdata    (rdw),
      .o_rvalid   (rvalid[g]),
`ifdef PS_LINEBUFFER_WIN_COUNT_EN
      .o_count    (count[g]),
`endif
      .o_line_done(line_done[g])
    );
    assign rdata[g] = 40'(rdw);
  end

  task automatic check(input string name, input logic [39:0] act,
                       input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] model_win(int base, int x, int k,
                                            bit rep);
    logic [39:0] w;
    int h;
    int i;
    logic [7:0] px;
    w = '0;
    h = (k - 1) / 2;
    for (int t = -h; t <= h; t++) begin
      i = x + t;
      if (i < 0) px = rep ? 8'(base) : 8'h00;
      else if (i >= LL) px = rep ? 8'(base + LL - 1) : 8'h00;
      else px = 8'(base + i);
      w = {w[31:0], px};
    end
    return w;
  endfunction

  function automatic logic [39:0] expect_win(int d, int base, int x);
    if (base == 'h10) begin
      if (d == 0) return T0[x];
      if (d == 1) return T1[x];
      return T2[x];
    end
    return model_win(base, x, (d == 2) ? 5 : 3, d != 0);
  endfunction

  task automatic write_line(input int d, input int base);
    for (int i = 0; i < LL; i++) begin
      @(negedge clk);
      wr[d] = 1'b1;
      wdata[d] = 8'(base + i);
    end
    @(negedge clk);
    wr[d] = 1'b0;
    check("rdy_low_in_prime", 40'(rdy[d]), 40'(0));
`ifdef PS_LINEBUFFER_WIN_COUNT_EN
    check("count_after_fill", 40'(count[d]), 40'(LL));
`endif
  endtask

  task automatic read_range(input int d, input int xa, input int xb,
                            input int base);
    exp_t e;
    int x;
    int budget;
    x = xa;
    budget = 0;
    while (x <= xb && budget < 50) begin
      @(negedge clk);
      rd[d] = 1'b1;
      if (rdy[d]) begin
        e.d = d;
        e.x = x;
        e.data = expect_win(d, base, x);
        e.last = (x == LL - 1);
        e.due = cyc + 1;
        exp_q.push_back(e);
        x++;
      end
      budget++;
    end
    if (x <= xb) check("read_timeout", 40'(x), 40'(xb + 1));
    @(negedge clk);
    rd[d] = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < N; d++) begin
      if (rvalid[d]) begin
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", 40'(rvalid[d]), 40'(0));
        end else begin
          e = exp_q.pop_front();
          check("window_dut", 40'(d), 40'(e.d));
          check("window_latency", 40'(cyc), 40'(e.due));
          check($sformatf("window_d%0d_x%0d", d, e.x), rdata[d], e.data);
          check("line_done", 40'(line_done[d]), 40'(e.last));
        end
      end else if (line_done[d]) begin
        check("line_done_stray", 40'(line_done[d]), 40'(0));
      end
    end
    if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check("rvalid_present", 40'(rvalid[e.d]), 40'(1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < N; d++) begin
      wr[d] = 1'b0;
      rd[d] = 1'b0;
      wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check("reset_rdy", 40'(rdy[d]), 40'(0));
      check("reset_rvalid", 40'(rvalid[d]), 40'(0));
      check("reset_rdata", rdata[d], 40'(0));
      check("reset_wr_drop", 40'(wr_drop[d]), 40'(0));
    end
    rst = 1'b0;

    // zero-pad line, back-to-back reads
    write_line(0, 'h10);
    read_range(0, 0, LL - 1, 'h10);
    check("rdy_after_line", 40'(rdy[0]), 40'(0));

    // replicate; reads requested during fill must be ignored
    rd[1] = 1'b1;
    write_line(1, 'h10);
    read_range(1, 0, LL - 1, 'h10);
    check("rdy_after_line_rep", 40'(rdy[1]), 40'(0));

    // five-tap replicate
    write_line(2, 'h10);
    read_range(2, 0, LL - 1, 'h10);

    // stall after x=3
    write_line(0, 'h10);
    read_range(0, 0, 3, 'h10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rvalid", 40'(rvalid[0]), 40'(0));
      check("stall_rdata", rdata[0], 40'h121314);
      check("stall_rdy", 40'(rdy[0]), 40'(1));
    end
    read_range(0, 4, LL - 1, 'h10);

    // ninth write lands in PRIME and is dropped
    write_line(0, 'h10);
    wr[0] = 1'b1;
    wdata[0] = 8'hAA;
    @(negedge clk);
    wr[0] = 1'b0;
    check("wr_drop_pulse", 40'(wr_drop[0]), 40'(1));
    @(negedge clk);
    check("wr_drop_single", 40'(wr_drop[0]), 40'(0));
    read_range(0, 0, LL - 1, 'h10);
    write_line(0, 'h20);
    read_range(0, 0, LL - 1, 'h20);

    // reset mid-line, then a fresh line
    write_line(0, 'h10);
    read_range(0, 0, 3, 'h10);
    #2 rst = 1'b1;
    #1;
    check("midrst_rdy", 40'(rdy[0]), 40'(0));
    check("midrst_rdata", rdata[0], 40'(0));
    check("midrst_rvalid", 40'(rvalid[0]), 40'(0));
    check("midrst_line_done", 40'(line_done[0]), 40'(0));
`ifdef PS_LINEBUFFER_WIN_COUNT_EN
    check("midrst_count", 40'(count[0]), 40'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    write_line(0, 'h30);
    read_range(0, 0, LL - 1, 'h30);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 40'(exp_q.size()), 40'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
